fix2flt: RTL and testbench
==========================

# fix2flt

Sequential converter from 16-bit sign-magnitude fixed point to IEEE half-precision float. The format is sign bit 15, then a 15-bit magnitude with 7 integer and 8 fraction bits. It is the reverse-direction companion of the float-to-fixed program. It sits beside the test-bench-driven top level and owns one port of data memory. On a start/ack handshake it reads two source bytes, normalizes iteratively, rounds, writes two result bytes, and pulses `done`.

## Interface
- `SRC_ADDR`, default 8'd0: address of the input low byte; the high byte is at `SRC_ADDR+1`.
- `DST_ADDR`, default 8'd2: address of the output low byte; the high byte is at `DST_ADDR+1`.
- `clk  input  1  clock`
- `reset  input  1  synchronous reset, active-low`
- `start  input  1  request from test bench; the conversion is triggered by its falling edge`
- `done  output  1  one-cycle acknowledge pulse`
- `busy  output  1  high in every non-IDLE state`
- `dm_addr  output  8  data memory address`
- `dm_rd_data  input  8  data memory read data (combinational, same cycle as address)`
- `dm_wr_data  output  8  data memory write data`
- `dm_wr_en  output  1  data memory write strobe`

## Operation
- `start_q` is `start` registered. A trigger occurs when `start_q && !start` in IDLE. Triggers in any other state are ignored.
- States: IDLE, RD_LO, RD_HI, NORM, ROUND, WR_LO, WR_HI, DONE.
- **IDLE** → RD_LO on a trigger.
- **RD_LO**: `dm_addr=SRC_ADDR`; capture the low byte.
- **RD_HI**: `dm_addr=SRC_ADDR+1`; capture `sign` = bit 7 and the magnitude high bits. Sets the 5-bit exponent register to 21.
- **NORM**, one action per cycle:
  - If magnitude==0: result = `{sign,15'b0}`, go to WR_LO.
  - Else if `mag[14]`: go to ROUND.
  - Else `mag<<=1`, `exp-=1`, stay in NORM.
- **ROUND** (round-nearest-even):
  - `mant=mag[13:4]`, `guard=mag[3]`, `sticky=|mag[2:0]`.
  - Increment `mant` when `guard && (sticky || mant[0])`.
  - If `mant` overflows past 10'h3FF: `mant=0`, `exp+=1`.
  - Result = `{sign,exp,mant}`.
- **WR_LO**: `dm_addr=DST_ADDR`, write result[7:0], `dm_wr_en=1`.
- **WR_HI**: `dm_addr=DST_ADDR+1`, write result[15:8], `dm_wr_en=1`.
- **DONE**: `done=1`, then go to IDLE.
- Arithmetic range:
  - The exponent range is 7..22. Subnormals, Inf and NaN are never produced.
  - The sign is always copied through, so 0x8000 produces 0x8000.
- Reset: all state returns to IDLE; `done`, `busy`, `dm_wr_en`, `dm_addr`, `dm_wr_data` and `start_q` go to 0. Reset mid-operation abandons the conversion; a partial write may remain in memory.

## Timing
- Cycle t0 is the IDLE cycle in which the trigger is seen.
- Let n = leading zeros of the 15-bit magnitude (0..14).
- Nonzero magnitude: NORM occupies t3..t3+n, ROUND t4+n, WR_LO t5+n, WR_HI t6+n. `done` is high in exactly cycle t7+n. Worst case is t21.
- Zero magnitude: NORM t3, WR_LO t4, WR_HI t5, `done` in t6.
- `dm_wr_en` is high for exactly 2 cycles per conversion; low byte first.
- `busy` falls in the cycle after DONE. A trigger is accepted from that IDLE cycle onward.

## Configuration
- `FIX2FLT_ROUND_EN` defined: round-nearest-even as specified.
- Undefined: `mant=mag[13:4]` is truncated and the exponent is never incremented. The ROUND state is still occupied for one cycle, so latency is identical.

## Structure
- Package `fix2flt_pkg` holds:
  - The state enum type.
  - `EXP_BIAS=15`, `FRAC_BITS=8`, `MAG_BITS=15`, `EXP_INIT=21`.
- One sub-module, `fix2flt_round`. It is combinational and maps mag[13:0] + exp to `{exp,mant}`. The macro is applied inside it.

## Test plan
- Memory 0x0100 (1.0) → writes 0x3C00; `done` at t13.
- 0x8180 (−1.5) → 0xBE00.
- 0x0001 (2^-8) → 0x1C00; `done` at t21.
- 0x0000 → 0x0000 and 0x8000 → 0x8000; `done` at t6.
- Rounding cases:
  - 0x4008 → 0x5400 (tie, even, no increment).
  - 0x4018 → 0x5402.
  - 0x7FFF → 0x5800 (mantissa carry into exponent). Without `FIX2FLT_ROUND_EN`, 0x7FFF → 0x57FF.
- Control cases:
  - `reset` low during NORM → `busy`/`done` go to 0 the next cycle, and no further writes occur.
  - `start` toggled while busy → ignored.
  - A back-to-back second trigger immediately after DONE → converts correctly.

Source files
------------

// File: rtl/fix2flt_pkg.sv
// fix2flt_pkg
//   Shared types and constants for the sign-magnitude fixed point (Q7.8) to
//   IEEE half-precision converter.
//   - state_t   : controller states
//   - EXP_BIAS  : half-precision exponent bias
//   - FRAC_BITS : fraction bits of the fixed-point magnitude
//   - MAG_BITS  : magnitude width (sign excluded)
//   - EXP_INIT  : biased exponent for a magnitude whose MSB is already set
package fix2flt_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD_LO = 3'd1,
        S_RD_HI = 3'd2,
        S_NORM  = 3'd3,
        S_ROUND = 3'd4,
        S_WR_LO = 3'd5,
        S_WR_HI = 3'd6,
        S_DONE  = 3'd7
    } state_t;

    localparam int EXP_BIAS  = 15;
    localparam int FRAC_BITS = 8;
    localparam int MAG_BITS  = 15;

    // mag[14] carries weight 2^(14-FRAC_BITS) = 2^6, so the biased exponent
    // is 15 + 6 = 21 before any normalizing shift.
    localparam logic [4:0] EXP_INIT = 5'(EXP_BIAS + (MAG_BITS - 1) - FRAC_BITS);

endpackage

// File: rtl/fix2flt_round.sv
// fix2flt_round
//   Combinational mantissa rounding for a normalized magnitude (mag[14]=1,
//   hidden bit dropped).
//   Build option: FIX2FLT_ROUND_EN
//     defined   -> round to nearest, ties to even; mantissa carry bumps exp
//     undefined -> mantissa truncated, exponent passed through unchanged
//   Ports:
//     i_mag      [13:0] magnitude bits below the hidden bit
//     i_exp      [4:0]  biased exponent after normalization
//     o_exp_mant [14:0] {exp, mant}
module fix2flt_round (
    input  logic [13:0] i_mag,
    input  logic [4:0]  i_exp,
    output logic [14:0] o_exp_mant
);

`ifdef FIX2FLT_ROUND_EN
    logic        w_inc;
    logic [10:0] w_mant_sum;

    always_comb begin
        // guard && (sticky || lsb): round up above half, or at half when odd
        w_inc      = i_mag[3] && ((|i_mag[2:0]) || i_mag[4]);
        w_mant_sum = {1'b0, i_mag[13:4]} + {10'd0, w_inc};
        if (w_mant_sum[10]) begin
            // 1.111..1 rounded up becomes 10.0: renormalize into the exponent
            o_exp_mant = {i_exp + 5'd1, 10'd0};
        end else begin
            o_exp_mant = {i_exp, w_mant_sum[9:0]};
        end
    end
`else
    logic w_unused_lsb;

    assign w_unused_lsb = ^i_mag[3:0];
    assign o_exp_mant   = {i_exp, i_mag[13:4]};
`endif

endmodule

// File: rtl/fix2flt.sv
// fix2flt
//   Sequential converter: reads a 16-bit sign-magnitude Q7.8 value from data
//   memory (two bytes), normalizes one bit per cycle, rounds, writes the
//   half-precision result back as two bytes and pulses done.
//   Build option: FIX2FLT_ROUND_EN (applied in fix2flt_round).
//   Parameters:
//     SRC_ADDR  address of the input low byte (high byte at +1)
//     DST_ADDR  address of the output low byte (high byte at +1)
//   Ports:
//     clk         clock
//     reset       synchronous reset, active low
//     start       request; falling edge seen in IDLE triggers a conversion
//     done        one-cycle completion pulse
//     busy        high in every non-IDLE state
//     dm_addr     data memory address
//     dm_rd_data  data memory read data (combinational)
//     dm_wr_data  data memory write data
//     dm_wr_en    data memory write strobe
//
//   state   | meaning
//   --------+-------------------------------------------------
//   IDLE    | wait for falling edge on start
//   RD_LO   | read source low byte
//   RD_HI   | read source high byte (sign, mag[14:8]), exp=21
//   NORM    | shift left until mag[14]=1, or detect zero
//   ROUND   | register rounded {sign, exp, mant}
//   WR_LO   | write result[7:0]
//   WR_HI   | write result[15:8]
//   DONE    | pulse done
module fix2flt
    import fix2flt_pkg::*;
#(
    parameter logic [7:0] SRC_ADDR = 8'd0,
    parameter logic [7:0] DST_ADDR = 8'd2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       done,
    output logic       busy,
    output logic [7:0] dm_addr,
    input  logic [7:0] dm_rd_data,
    output logic [7:0] dm_wr_data,
    output logic       dm_wr_en
);

    state_t               r_state;
    state_t               w_next;
    logic                 r_start_q;
    logic                 r_sign;
    logic [MAG_BITS-1:0]  r_mag;
    logic [4:0]           r_exp;
    logic [15:0]          r_result;
    logic [14:0]          w_exp_mant;
    logic                 w_trigger;

    assign w_trigger = r_start_q && !start;

    fix2flt_round u_round (
        .i_mag      (r_mag[13:0]),
        .i_exp      (r_exp),
        .o_exp_mant (w_exp_mant)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_start_q <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_start_q <= start;
        end
    end

    always_comb begin
        w_next     = r_state;
        busy       = (r_state != S_IDLE);
        done       = 1'b0;
        dm_addr    = 8'd0;
        dm_wr_data = 8'd0;
        dm_wr_en   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_trigger) w_next = S_RD_LO;
            end
            S_RD_LO: begin
                dm_addr = SRC_ADDR;
                w_next  = S_RD_HI;
            end
            S_RD_HI: begin
                dm_addr = SRC_ADDR + 8'd1;
                w_next  = S_NORM;
            end
            S_NORM: begin
                if (r_mag == '0)  w_next = S_WR_LO;
                else if (r_mag[14]) w_next = S_ROUND;
            end
            S_ROUND: begin
                w_next = S_WR_LO;
            end
            S_WR_LO: begin
                dm_addr    = DST_ADDR;
                dm_wr_data = r_result[7:0];
                dm_wr_en   = 1'b1;
                w_next     = S_WR_HI;
            end
            S_WR_HI: begin
                dm_addr    = DST_ADDR + 8'd1;
                dm_wr_data = r_result[15:8];
                dm_wr_en   = 1'b1;
                w_next     = S_DONE;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sign   <= 1'b0;
            r_mag    <= '0;
            r_exp    <= 5'd0;
            r_result <= 16'd0;
        end else begin
            case (r_state)
                S_RD_LO: begin
                    r_mag[7:0] <= dm_rd_data;
                end
                S_RD_HI: begin
                    r_sign      <= dm_rd_data[7];
                    r_mag[14:8] <= dm_rd_data[6:0];
                    r_exp       <= EXP_INIT;
                end
                S_NORM: begin
                    if (r_mag == '0) begin
                        r_result <= {r_sign, 15'd0};
                    end else if (!r_mag[14]) begin
                        r_mag <= r_mag << 1;
                        r_exp <= r_exp - 5'd1;
                    end
                end
                S_ROUND: begin
                    r_result <= {r_sign, w_exp_mant};
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fix2flt.sv
module tb_fix2flt;

    localparam logic [7:0] SRC = 8'd0;
    localparam logic [7:0] DST = 8'd2;

    logic       clk;
    logic       reset;
    logic       start;
    logic       done;
    logic       busy;
    logic [7:0] dm_addr;
    logic [7:0] dm_rd_data;
    logic [7:0] dm_wr_data;
    logic       dm_wr_en;

    logic [7:0] mem [0:255];

    int checks;
    int failures;

    fix2flt #(.SRC_ADDR(SRC), .DST_ADDR(DST)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .done       (done),
        .busy       (busy),
        .dm_addr    (dm_addr),
        .dm_rd_data (dm_rd_data),
        .dm_wr_data (dm_wr_data),
        .dm_wr_en   (dm_wr_en)
    );

    assign dm_rd_data = mem[dm_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Runs one conversion. Entry: #1 after a posedge, in IDLE. Exit: #1 after
    // the posedge that ends DONE.
    task automatic convert(input string tag, input logic [15:0] src,
                           input logic [15:0] expv, input int exp_cyc,
                           input bit pre_armed, input bit arm_next, input bit glitch);
        int         c;
        int         nwr;
        bit         got;
        logic [15:0] res;
        logic [7:0]  first_addr;
        mem[SRC]        = src[7:0];
        mem[SRC + 8'd1] = src[15:8];
        if (!pre_armed) begin
            start = 1'b1;
            @(posedge clk);
            #1;
        end
        start      = 1'b0;
        c          = 0;
        nwr        = 0;
        got        = 1'b0;
        res        = 16'h0000;
        first_addr = 8'hFF;
        while (c < 40) begin
            @(negedge clk);
            if (glitch && c == 5) start = 1'b1;
            if (glitch && c == 7) start = 1'b0;
            if (dm_wr_en) begin
                if (nwr == 0) first_addr = dm_addr;
                if (dm_addr == DST) res[7:0] = dm_wr_data;
                else if (dm_addr == DST + 8'd1) res[15:8] = dm_wr_data;
                nwr++;
            end
            if (done) begin
                got = 1'b1;
                break;
            end
            @(posedge clk);
            c++;
        end
        chk({tag, "_done_seen"}, 32'(got), 32'd1);
        chk({tag, "_done_cycle"}, 32'(c), 32'(exp_cyc));
        chk({tag, "_result"}, 32'(res), 32'(expv));
        chk({tag, "_wr_count"}, 32'(nwr), 32'd2);
        chk({tag, "_first_wr_addr"}, 32'(first_addr), 32'(DST));
        if (arm_next) start = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, "_busy_after"}, 32'(busy), 32'd0);
        chk({tag, "_done_width"}, 32'(done), 32'd0);
    endtask

    initial begin
        int nwr;
        checks   = 0;
        failures = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        reset = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_wr_en", 32'(dm_wr_en), 32'd0);
        chk("rst_addr", 32'(dm_addr), 32'd0);
        chk("rst_wr_data", 32'(dm_wr_data), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        convert("one",      16'h0100, 16'h3C00, 13, 1'b0, 1'b0, 1'b0);
        convert("neg1p5",   16'h8180, 16'hBE00, 13, 1'b0, 1'b0, 1'b0);
        convert("min",      16'h0001, 16'h1C00, 21, 1'b0, 1'b0, 1'b0);
        convert("zero",     16'h0000, 16'h0000, 6,  1'b0, 1'b0, 1'b0);
        convert("negzero",  16'h8000, 16'h8000, 6,  1'b0, 1'b0, 1'b0);
        convert("tie_even", 16'h4008, 16'h5400, 7,  1'b0, 1'b0, 1'b0);
`ifdef FIX2FLT_ROUND_EN
        convert("tie_odd",  16'h4018, 16'h5402, 7,  1'b0, 1'b0, 1'b0);
        convert("carry",    16'h7FFF, 16'h5800, 7,  1'b0, 1'b1, 1'b0);
`else
        convert("tie_odd",  16'h4018, 16'h5401, 7,  1'b0, 1'b0, 1'b0);
        convert("carry",    16'h7FFF, 16'h57FF, 7,  1'b0, 1'b1, 1'b0);
`endif
        // second trigger armed during the previous DONE
        convert("b2b",      16'h0180, 16'h3E00, 13, 1'b1, 1'b0, 1'b0);
        // start toggled while busy must not restart or add a conversion
        convert("glitch",   16'h0001, 16'h1C00, 21, 1'b0, 1'b0, 1'b1);
        nwr = 0;
        repeat (5) begin
            @(negedge clk);
            if (busy || dm_wr_en) nwr++;
        end
        chk("glitch_no_extra", 32'(nwr), 32'd0);

        // reset in the middle of NORM
        mem[DST]        = 8'hA5;
        mem[DST + 8'd1] = 8'h5A;
        mem[SRC]        = 8'h01;
        mem[SRC + 8'd1] = 8'h00;
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("mid_busy_before", 32'(busy), 32'd1);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        nwr = 0;
        repeat (25) begin
            @(negedge clk);
            if (dm_wr_en || done || busy) nwr++;
        end
        chk("mid_rst_no_activity", 32'(nwr), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
